multi_monitor: RTL and testbench

Parametrised multi-channel active IoT device counter. Each of `CHANNELS` independent counters tracks devices joining or leaving one network segment. Each counter has a selectable wrap or saturate mode, a per-channel threshold alarm and a sticky overflow flag. A registered aggregate total across all channels is also provided. The block sits between the per-segment event decoders and the status/register interface.

---
 rtl/multi_monitor.sv | 133 +++++++++++++
 tb/tb_multi_monitor.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/multi_monitor.sv
// ============================================================================
// Module   : multi_monitor
// Brief    : Per-segment IoT device counters (wrap/saturate), threshold alarm,
//            sticky overflow and a registered aggregate total.
//            Optional: MULTI_MONITOR_PEAK_EN adds per-channel peak tracking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_monitor #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int SATURATE    = 0,
    parameter int ALARM_LEVEL = 200
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [CHANNELS-1:0]               change,
    input  logic [CHANNELS-1:0]               on_off,
    input  logic [CHANNELS-1:0]               clear,
    output logic [CHANNELS*WIDTH-1:0]         counter_out,
    output logic [WIDTH+$clog2(CHANNELS):0]   total_out,
    output logic [CHANNELS-1:0]               alarm,
    output logic [CHANNELS-1:0]               overflow
`ifdef MULTI_MONITOR_PEAK_EN
    ,
    output logic [CHANNELS*WIDTH-1:0]         peak_out
`endif
);

    localparam int               c_total_w     = WIDTH + $clog2(CHANNELS) + 1;
    localparam logic [WIDTH-1:0] c_count_max   = '1;
    localparam logic [WIDTH-1:0] c_alarm_level = WIDTH'(ALARM_LEVEL);

    logic [c_total_w-1:0] w_sum;
    logic [c_total_w-1:0] r_total;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [WIDTH-1:0] r_count;
        logic [WIDTH-1:0] w_count_next;
        logic             r_ovf;
        logic             w_ovf_next;
        logic             r_alarm;

        // Priority: clear, then hold, then the up/down step with boundary handling.
        always_comb begin
            w_count_next = r_count;
            w_ovf_next   = r_ovf;
            if (clear[i]) begin
                w_count_next = '0;
                w_ovf_next   = 1'b0;
            end else if (change[i]) begin
                if (on_off[i]) begin
                    if (r_count == c_count_max) begin
                        w_ovf_next   = 1'b1;
                        w_count_next = (SATURATE != 0) ? r_count : '0;
                    end else begin
                        w_count_next = r_count + 1'b1;
                    end
                end else begin
                    if (r_count == '0) begin
                        w_ovf_next   = 1'b1;
                        w_count_next = (SATURATE != 0) ? r_count : c_count_max;
                    end else begin
                        w_count_next = r_count - 1'b1;
                    end
                end
            end
        end

        // Alarm is evaluated on the next count so it lines up with counter_out.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
                r_alarm <= 1'b0;
            end else begin
                r_count <= w_count_next;
                r_ovf   <= w_ovf_next;
                r_alarm <= (w_count_next >= c_alarm_level);
            end
        end

        assign counter_out[i*WIDTH +: WIDTH] = r_count;
        assign overflow[i]                   = r_ovf;
        assign alarm[i]                      = r_alarm;

`ifdef MULTI_MONITOR_PEAK_EN
        logic [WIDTH-1:0] r_peak;
        logic [WIDTH-1:0] w_peak_next;

        always_comb begin
            w_peak_next = r_peak;
            if (clear[i]) begin
                w_peak_next = '0;
            end else if (w_count_next > r_peak) begin
                w_peak_next = w_count_next;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_peak <= '0;
            end else begin
                r_peak <= w_peak_next;
            end
        end

        assign peak_out[i*WIDTH +: WIDTH] = r_peak;
`endif
    end

    // Sum of the registered counts; total therefore trails the counters by one cycle.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_sum = w_sum + c_total_w'(counter_out[k*WIDTH +: WIDTH]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total <= '0;
        end else begin
            r_total <= w_sum;
        end
    end

    assign total_out = r_total;

endmodule

`default_nettype wire

// File: tb/tb_multi_monitor.sv
// ============================================================================
// Module   : tb_multi_monitor
// Brief    : Directed self-checking bench for multi_monitor (wrap and saturate
//            instances; peak checks when MULTI_MONITOR_PEAK_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  change = '0, on_off = '0, clear = '0;
    logic [3:0]  s_change = '0, s_on_off = '0, s_clear = '0;
    logic [31:0] counter_out, s_counter_out;
    logic [10:0] total_out, s_total_out;
    logic [3:0]  alarm, overflow, s_alarm, s_overflow;
`ifdef MULTI_MONITOR_PEAK_EN
    logic [31:0] peak_out, s_peak_out;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_monitor #(.WIDTH(8), .CHANNELS(4), .SATURATE(0), .ALARM_LEVEL(200)) dut (
        .clk(clk), .rst_n(rst_n), .change(change), .on_off(on_off), .clear(clear),
        .counter_out(counter_out), .total_out(total_out), .alarm(alarm), .overflow(overflow)
`ifdef MULTI_MONITOR_PEAK_EN
        , .peak_out(peak_out)
`endif
    );

    multi_monitor #(.WIDTH(8), .CHANNELS(4), .SATURATE(1), .ALARM_LEVEL(200)) dut_sat (
        .clk(clk), .rst_n(rst_n), .change(s_change), .on_off(s_on_off), .clear(s_clear),
        .counter_out(s_counter_out), .total_out(s_total_out), .alarm(s_alarm), .overflow(s_overflow)
`ifdef MULTI_MONITOR_PEAK_EN
        , .peak_out(s_peak_out)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset held from time 0
        #2;
        chk("rst0_counter", counter_out, 0);
        chk("rst0_total", total_out, 0);
        chk("rst0_flags", {alarm, overflow}, 0);
        chk("rst0_sat_counter", s_counter_out, 0);
        tick(2);
        rst_n = 1'b1;

        // Count ch0 to 37, then reset asynchronously mid-count
        change = 4'b0001; on_off = 4'b0001;
        tick(37);
        change = '0;
        chk("pre_rst_ch0", counter_out[7:0], 37);
        tick();
        chk("pre_rst_total", total_out, 37);
        rst_n = 1'b0;
        #1;
        chk("async_rst_counter", counter_out, 0);
        chk("async_rst_total", total_out, 0);
        chk("async_rst_flags", {alarm, overflow}, 0);
        #2;
        rst_n = 1'b1;
        change = 4'b0001; on_off = 4'b0001;
        tick();
        chk("post_rst_ch0", counter_out[7:0], 1);
        chk("post_rst_total", total_out, 0);
        change = '0;

        // Wrap mode boundaries
        clear = 4'hF; tick(); clear = '0;
        change = 4'b0010; on_off = 4'b0010;
        tick(255);
        chk("wrap_ch1_255", counter_out[15:8], 255);
        chk("wrap_ovf_none", overflow, 4'b0000);
        change = 4'b0110; on_off = 4'b0010;
        tick();
        chk("wrap_ch1_up_to0", counter_out[15:8], 0);
        chk("wrap_ch2_down_to255", counter_out[23:16], 255);
        chk("wrap_ovf_set", overflow, 4'b0110);
        chk("wrap_alarm_ch2", alarm, 4'b0100);
        change = '0; clear = 4'b0010;
        tick();
        clear = '0;
        chk("wrap_clear_ovf1", overflow, 4'b0100);
        chk("wrap_ch2_held", counter_out[23:16], 255);

        // Saturate mode boundaries
        s_change = 4'b0001; s_on_off = 4'b0001;
        tick(300);
        chk("sat_ch0_255", s_counter_out[7:0], 255);
        chk("sat_ovf0", s_overflow, 4'b0001);
        s_on_off = 4'b0000;
        tick();
        chk("sat_ch0_254", s_counter_out[7:0], 254);
        chk("sat_ovf0_sticky", s_overflow, 4'b0001);
        s_change = 4'b0010; s_on_off = 4'b0000;
        tick();
        s_change = '0;
        chk("sat_ch1_hold0", s_counter_out[15:8], 0);
        chk("sat_ovf1", s_overflow, 4'b0011);

        // Alarm threshold on ch3
        clear = 4'hF; tick(); clear = '0;
        change = 4'b1000; on_off = 4'b1000;
        tick(198);
        chk("alarm_198", {counter_out[31:24], alarm}, {8'd198, 4'b0000});
        tick();
        chk("alarm_199", {counter_out[31:24], alarm}, {8'd199, 4'b0000});
        tick();
        chk("alarm_200", {counter_out[31:24], alarm}, {8'd200, 4'b1000});
        on_off = 4'b0000;
        tick();
        chk("alarm_back_199", {counter_out[31:24], alarm}, {8'd199, 4'b0000});
        change = '0;

        // Concurrency and hold
        clear = 4'hF; tick(); clear = '0;
        change = 4'hF; on_off = 4'hF;
        tick(10);
        chk("conc_all10", counter_out, 32'h0A0A_0A0A);
        change = 4'b1011; on_off = 4'b0001; clear = 4'b1000;
        tick();
        chk("conc_mixed", counter_out, 32'h000A_090B);
        chk("conc_total_prev", total_out, 40);
        change = '0; clear = '0;
        tick();
        chk("conc_total_30", total_out, 30);
        change = 4'b0100; on_off = 4'b0100; clear = 4'b0100;
        tick();
        change = '0; clear = '0;
        chk("conc_clear_wins", counter_out, 32'h0000_090B);

`ifdef MULTI_MONITOR_PEAK_EN
        clear = 4'hF; tick(); clear = '0;
        change = 4'b0001; on_off = 4'b0001;
        tick(5);
        on_off = 4'b0000;
        tick(2);
        change = '0;
        chk("peak_count3", counter_out[7:0], 3);
        chk("peak_5", peak_out[7:0], 5);
        clear = 4'b0001;
        tick();
        clear = '0;
        chk("peak_cleared", peak_out[7:0], 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
